// File: rtl/mine_scheduler.sv
// Nonce scheduler: issues one hash job at a time to the engine, compares results
// against the target, and reports hits or range exhaustion. Supports restart/abort.
module mine_scheduler #(
  parameter int HDR_W  = 640,
  parameter int HASH_W = 256
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hdr_valid,
  output logic              hdr_ready,
  input  logic [HDR_W-1:0]  blockHeader,
  input  logic [31:0]       nonce_end,
  input  logic [HASH_W-1:0] target,
  input  logic              abort,
  output logic              core_start,
  output logic [HDR_W-1:0]  core_header,
  input  logic              core_done,
  input  logic [HASH_W-1:0] core_hash,
  output logic              found_valid,
  input  logic              found_ready,
  output logic [31:0]       found_nonce,
  output logic [31:0]       found_hash_msw,
  output logic              busy,
  output logic              exhausted,
  output logic [31:0]       hash_count
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, FOUND} state_t;

  state_t              r_state;
  logic [HDR_W-1:32]   r_hdr_hi;
  logic [31:0]         r_nonce;
  logic [31:0]         r_end;
  logic [HASH_W-1:0]   r_tgt;
  // A header accepted mid-job parks here so core_header stays frozen while draining
  logic [HDR_W-1:0]    r_pend_hdr;
  logic [31:0]         r_pend_end;
  logic [HASH_W-1:0]   r_pend_tgt;
  logic                r_restart;
  logic                r_exh;
  logic [31:0]         r_cnt;
  logic [31:0]         r_fnonce;
  logic [31:0]         r_fmsw;

  logic        w_acc;
  logic        w_hit;
  logic [31:0] w_cnt_inc;

  assign hdr_ready      = (r_state != FOUND);
  assign w_acc          = hdr_valid & hdr_ready;
  assign w_hit          = (core_hash < r_tgt);
  assign w_cnt_inc      = (r_cnt == 32'hFFFF_FFFF) ? r_cnt : r_cnt + 32'd1;
  assign core_start     = (r_state == ISSUE);
  assign core_header    = {r_hdr_hi, r_nonce};
  assign found_valid    = (r_state == FOUND);
  assign found_nonce    = r_fnonce;
  assign found_hash_msw = r_fmsw;
  assign busy           = (r_state != IDLE);
  assign exhausted      = r_exh;
  assign hash_count     = r_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hdr_hi   <= '0;
      r_nonce    <= '0;
      r_end      <= '0;
      r_tgt      <= '0;
      r_pend_hdr <= '0;
      r_pend_end <= '0;
      r_pend_tgt <= '0;
      r_restart  <= 1'b0;
      r_exh      <= 1'b0;
      r_cnt      <= '0;
      r_fnonce   <= '0;
      r_fmsw     <= '0;
    end else begin
      case (r_state)
        IDLE: if (hdr_valid) begin
          {r_hdr_hi, r_nonce} <= blockHeader;
          r_end     <= nonce_end;
          r_tgt     <= target;
          r_exh     <= 1'b0;
          r_cnt     <= '0;
          r_restart <= 1'b0;
          r_state   <= ISSUE;
        end
        ISSUE: begin
          if (abort) begin
            r_restart <= 1'b0;
            r_state   <= DRAIN;
          end else if (w_acc) begin
            r_pend_hdr <= blockHeader;
            r_pend_end <= nonce_end;
            r_pend_tgt <= target;
            r_cnt      <= '0;
            r_exh      <= 1'b0;
            r_restart  <= 1'b1;
            r_state    <= DRAIN;
          end else begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (abort) begin
            r_restart <= 1'b0;
            r_state   <= core_done ? IDLE : DRAIN;
          end else if (w_acc) begin
            r_cnt <= '0;
            r_exh <= 1'b0;
            if (core_done) begin
              // engine is free already: start the new header without draining
              {r_hdr_hi, r_nonce} <= blockHeader;
              r_end     <= nonce_end;
              r_tgt     <= target;
              r_restart <= 1'b0;
              r_state   <= ISSUE;
            end else begin
              r_pend_hdr <= blockHeader;
              r_pend_end <= nonce_end;
              r_pend_tgt <= target;
              r_restart  <= 1'b1;
              r_state    <= DRAIN;
            end
          end else if (core_done) begin
            r_cnt <= w_cnt_inc;
            if (w_hit) begin
              r_fnonce <= r_nonce;
              r_fmsw   <= core_hash[HASH_W-1 -: 32];
              r_state  <= FOUND;
            end else if (r_nonce == r_end) begin
              r_exh   <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_nonce <= r_nonce + 32'd1;
              r_state <= ISSUE;
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            r_restart <= 1'b0;
            if (core_done) r_state <= IDLE;
          end else if (w_acc) begin
            r_cnt <= '0;
            r_exh <= 1'b0;
            if (core_done) begin
              {r_hdr_hi, r_nonce} <= blockHeader;
              r_end     <= nonce_end;
              r_tgt     <= target;
              r_restart <= 1'b0;
              r_state   <= ISSUE;
            end else begin
              r_pend_hdr <= blockHeader;
              r_pend_end <= nonce_end;
              r_pend_tgt <= target;
              r_restart  <= 1'b1;
            end
          end else if (core_done) begin
            if (r_restart) begin
              {r_hdr_hi, r_nonce} <= r_pend_hdr;
              r_end     <= r_pend_end;
              r_tgt     <= r_pend_tgt;
              r_restart <= 1'b0;
              r_state   <= ISSUE;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        FOUND: if (found_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mine_scheduler.md
# mine_scheduler

Sequencing controller between the serial receive path and the hash datapath. Accepts a 640-bit block header from the UART core and issues hash jobs to a single hash engine over a start/done handshake, one nonce at a time. Each returned hash is compared against a 256-bit target. A hit is handed to the transmit path via valid/ready; the block reports exhaustion when the nonce range is finished. It replaces free-running nonce increment with an explicit, abortable job schedule.

## Interface
Parameters:
- HDR_W, 640, header width; nonce occupies bits [31:0]
- HASH_W, 256, hash and target width

Ports:
- clock  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- hdr_valid  in  1  new header offered
- hdr_ready  out  1  header accepted when hdr_valid & hdr_ready
- blockHeader  in  HDR_W  header; [31:0] = start nonce
- nonce_end  in  32  last nonce to try, inclusive; sampled with header
- target  in  HASH_W  hit when core_hash < target, unsigned; sampled with header
- abort  in  1  stop current job
- core_start  out  1  one-cycle job start pulse
- core_header  out  HDR_W  {latched header[639:32], current nonce}; stable from start until next start
- core_done  in  1  one-cycle pulse; core_hash valid this cycle
- core_hash  in  HASH_W  engine result
- found_valid  out  1  hit available
- found_ready  in  1  transmit path consumes hit
- found_nonce  out  32  winning nonce
- found_hash_msw  out  32  core_hash[255:224] of hit
- busy  out  1  state is not IDLE
- exhausted  out  1  sticky: range finished without hit
- hash_count  out  32  hashes completed for current header, saturating

## Operation
States: IDLE, ISSUE, WAIT, DRAIN, FOUND.
- hdr_ready = 1 in every state except FOUND.
- IDLE: on accept, latch header, nonce_end, target. Set nonce = blockHeader[31:0]. Clear exhausted, hash_count and the restart flag. Go ISSUE.
- ISSUE: core_start = 1 for exactly one cycle. Go WAIT.
- WAIT on core_done:
  - hash_count += 1, saturating at 0xFFFFFFFF.
  - If hit: latch found_nonce and found_hash_msw, go FOUND.
  - Else if nonce == nonce_end: set exhausted, go IDLE.
  - Else nonce += 1, modulo 2^32 (0xFFFFFFFF wraps to 0), go ISSUE.
- FOUND: found_valid held high, data stable, until found_ready. Then go IDLE with found_valid low.
- Restart (hdr accept while in ISSUE, WAIT or DRAIN): latch the new header. Clear hash_count and exhausted. Set the restart flag and go DRAIN, unless core_done is high in WAIT that same cycle. In that case discard core_done and go directly to ISSUE.
- abort in ISSUE or WAIT: go DRAIN with restart flag clear. In WAIT with core_done the same cycle: discard the result, go IDLE.
- DRAIN: wait for core_done and discard it (no count, no compare). Then go ISSUE if the restart flag is set, else IDLE.
- Priority: abort over hdr accept over core_done. An abort in DRAIN clears the restart flag.
- abort in IDLE or FOUND: no effect.
- core_done in IDLE, ISSUE or FOUND: ignored.
- Range and wrap:
  - nonce_end == start gives 1 hash.
  - nonce_end < start wraps through 0.
  - nonce_end == start − 1 covers all 2^32 nonces.

## Timing
- Reset: state IDLE; all outputs 0 except hdr_ready = 1; nonce, hash_count and latches are 0.
- Header accepted at cycle N: core_start high at N+1, with core_header valid at N+1.
- core_done at cycle M:
  - no hit: next core_start at M+1 (2-cycle scheduler overhead per hash);
  - hit: found_valid high at M+1.
- found_valid & found_ready at cycle K: IDLE at K+1, found_valid low at K+1.
- Exhaustion: exhausted high at M+1 and busy low at M+1.
- core_header and the nonce register never change while in WAIT or DRAIN.
- Reset mid-job: returns to IDLE next cycle, regardless of outstanding core_done.

## Test plan
- Header with start 0x42A14695, nonce_end 0x42A14697, target all-ones; engine returns hash 0 → single core_start with nonce 0x42A14695; found_valid at done+1; found_nonce 0x42A14695; hash_count 1.
- Start 0x10, end 0x12, target 0; engine hash 0x01… each time → 3 starts (nonces 0x10, 0x11, 0x12); exhausted = 1; busy = 0; hash_count 3.
- Start 0xFFFFFFFE, end 0x00000001, hit on 4th hash → nonces FFFFFFFE, FFFFFFFF, 0, 1; found_nonce 0x00000001.
- abort asserted 2 cycles after core_start, core_done 5 cycles later → stays in DRAIN; IDLE the cycle after done; no count increment, no found_valid.
- New header during WAIT, old done arrives later → old done discarded; core_start with new header[31:0] the cycle after that done; hash_count 0 then 1.
- Hit with found_ready low 10 cycles; hdr_valid high throughout → found_valid and data held; hdr_ready 0; header accepted only after the IDLE return.
